// File: rtl/mux_select_arbiter.sv
// mux_select_arbiter: round-robin owner selection for a shared 4:1 select mux.
// Drives the mux select and a one-hot grant, inserts a one-cycle turnaround gap
// between owners, and bounds ownership at MAX_HOLD cycles when the optional
// hold limit is compiled in with `define ARB_HOLD_LIMIT_EN.
module mux_select_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [1:0]   sel,
  output logic         bus_en,
  output logic         owner_changed
);

  localparam int unsigned REQ_W  = 4;
  localparam int unsigned HOLD_W = 8;

  // Reject illegal configurations at elaboration time.
  if (N < 2 || N > 4 || MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_param_check
    $error("mux_select_arbiter: N must be 2..4 and MAX_HOLD 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [1:0]     sel_q, sel_d;
  logic           bus_en_q, bus_en_d;
  logic           owner_changed_q, owner_changed_d;
  logic [1:0]     last_owner_q, last_owner_d;
`ifdef ARB_HOLD_LIMIT_EN
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  logic [REQ_W-1:0] req_ext;
  logic             win_found;
  logic [1:0]       win_idx;
  logic [N-1:0]     win_onehot;
  logic             release_now;

  assign req_ext = REQ_W'(req);

  // Round-robin search starting one past the most recent owner.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = 2'd0;
    win_onehot = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!win_found && req[i] && (((32'(last_owner_q) + k) % N) == i)) begin
          win_found     = 1'b1;
          win_idx       = 2'(i);
          win_onehot[i] = 1'b1;
        end
      end
    end
  end

  // Owner gives up the bus on release, or on preemption at the hold limit.
  always_comb begin
    release_now = !req_ext[sel_q];
`ifdef ARB_HOLD_LIMIT_EN
    if ((hold_cnt_q == HOLD_W'(MAX_HOLD)) &&
        (|(req_ext & ~(REQ_W'(1) << sel_q)))) begin
      release_now = 1'b1;
    end
`endif
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    sel_d           = sel_q;
    bus_en_d        = bus_en_q;
    owner_changed_d = 1'b0;
    last_owner_d    = last_owner_q;
`ifdef ARB_HOLD_LIMIT_EN
    hold_cnt_d      = hold_cnt_q;
`endif
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (win_found) begin
          state_d         = ST_GRANT;
          gnt_d           = win_onehot;
          sel_d           = win_idx;
          bus_en_d        = 1'b1;
          owner_changed_d = 1'b1;
          last_owner_d    = win_idx;
`ifdef ARB_HOLD_LIMIT_EN
          hold_cnt_d      = HOLD_W'(1);
`endif
        end else begin
          state_d  = ST_IDLE;
          gnt_d    = '0;
          bus_en_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (release_now) begin
          state_d  = ST_GAP;
          gnt_d    = '0;
          bus_en_d = 1'b0;
        end
`ifdef ARB_HOLD_LIMIT_EN
        else if (hold_cnt_q != HOLD_W'(MAX_HOLD)) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
`endif
      end
      default: begin
        state_d  = ST_IDLE;
        gnt_d    = '0;
        bus_en_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      gnt_q           <= '0;
      sel_q           <= 2'd0;
      bus_en_q        <= 1'b0;
      owner_changed_q <= 1'b0;
      last_owner_q    <= 2'(N - 1);
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_q      <= '0;
`endif
    end else begin
      state_q         <= state_d;
      gnt_q           <= gnt_d;
      sel_q           <= sel_d;
      bus_en_q        <= bus_en_d;
      owner_changed_q <= owner_changed_d;
      last_owner_q    <= last_owner_d;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_q      <= hold_cnt_d;
`endif
    end
  end

  assign gnt           = gnt_q;
  assign sel           = sel_q;
  assign bus_en        = bus_en_q;
  assign owner_changed = owner_changed_q;

endmodule
